// File: rtl/rdata_router.sv
// rdata_router: per-slave read-data return path; in-order tag FIFO routes each data beat to its master.
// Optional head timeout with force-pop enabled by defining RDR_TIMEOUT_EN.
module rdata_router #(
  parameter int NUM_MASTERS = 2,
  parameter int MID_W       = 1,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int PTR_W       = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_accept,
  input  logic [MID_W-1:0]              rd_master,
  output logic                          rd_allow,
  input  logic                          rdata_valid,
  input  logic [DATA_W-1:0]             rdata_in,
  output logic [NUM_MASTERS*DATA_W-1:0] rdata,
  output logic [NUM_MASTERS-1:0]        data_read,
  output logic [PTR_W:0]                pend_cnt,
  output logic                          err_drop,
  output logic                          err_orphan,
  output logic                          err_timeout
);
  logic [MID_W-1:0] tags [DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [MID_W-1:0] head;
  logic [DATA_W-1:0] pop_val;
  logic empty, full, pop, tmo_pop, push, bad;

  // pointers carry an extra wrap bit so full and empty are distinguishable
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head     = tags[rd_ptr[PTR_W-1:0]];
  assign bad      = int'(rd_master) >= NUM_MASTERS;
  assign pop      = (rdata_valid && !empty) || tmo_pop;
  assign push     = rd_accept && !bad && (!full || pop);
  assign pop_val  = rdata_valid ? rdata_in : '1;
  assign rd_allow = !full;
  assign pend_cnt = wr_ptr - rd_ptr;

`ifdef RDR_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  logic [7:0] tmo_cnt;
  // real data in the timeout cycle wins; the forced pop only fires without it
  assign tmo_pop = !empty && !rdata_valid && tmo_cnt == TMO;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      tmo_cnt     <= (empty || pop) ? '0 : tmo_cnt + 8'd1;
      err_timeout <= tmo_pop;
    end
  end
`else
  assign tmo_pop     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr[PTR_W-1:0]] <= rd_master;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_drop   <= 1'b0;
      err_orphan <= 1'b0;
      data_read  <= '0;
      rdata      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (rd_accept && !push) err_drop <= 1'b1;
      if (rdata_valid && empty) err_orphan <= 1'b1;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        data_read[i]                <= pop && int'(head) == i;
        rdata[i*DATA_W +: DATA_W]   <= (pop && int'(head) == i) ? pop_val : '0;
      end
    end
  end
endmodule
